alu_share_ctrl: RTL and testbench

Two-port arbiter and sequencer that shares one 20-bit ALU between two independent requesters, such as a datapath issue port and a debug/DMA port. Each requester hands over operands and an opcode with a valid/ready handshake. The block grants the ALU round-robin, runs the operation in a registered EXEC cycle, and returns the result and flags on the winner's response channel with valid/ready backpressure.

---
 rtl/alu_pkg.sv | 23 ++
 rtl/alu_rr_pick.sv | 9 +
 rtl/alu_share_ctrl.sv | 114 +++++++++++
 tb/tb_alu_share_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes, FSM states and the ALU function for alu_share_ctrl.
package alu_pkg;
    localparam int DATA_W  = 20;
    localparam int SHAMT_W = 5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_SHL  = 3'b100;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

    // Unused opcodes return zero; arithmetic wraps at DATA_W bits.
    function automatic logic [DATA_W-1:0] alu_calc(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                   input logic [2:0] op);
        return op == OP_ADD  ? a + b :
               op == OP_SUB  ? a - b :
               op == OP_OR   ? a | b :
               op == OP_NAND ? ~(a & b) :
               op == OP_SHL  ? a << b[SHAMT_W-1:0] : '0;
    endfunction
endpackage

// File: rtl/alu_rr_pick.sv
// alu_rr_pick: two-input round-robin grant; prio_i names the winner when both request.
module alu_rr_pick (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    output logic [1:0] grant_o
);
    assign grant_o[0] = valid_i[0] & (~valid_i[1] | ~prio_i);
    assign grant_o[1] = valid_i[1] & (~valid_i[0] | prio_i);
endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one registered ALU between two valid/ready requesters, round-robin.
module alu_share_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_0,
    output logic              req_ready_0,
    input  logic [DATA_W-1:0] req_a_0,
    input  logic [DATA_W-1:0] req_b_0,
    input  logic [2:0]        req_op_0,
    output logic              resp_valid_0,
    input  logic              resp_ready_0,
    output logic [DATA_W-1:0] resp_data_0,
    output logic              resp_zero_0,
    output logic              resp_neg_0,
    output logic              resp_par_0,
    input  logic              req_valid_1,
    output logic              req_ready_1,
    input  logic [DATA_W-1:0] req_a_1,
    input  logic [DATA_W-1:0] req_b_1,
    input  logic [2:0]        req_op_1,
    output logic              resp_valid_1,
    input  logic              resp_ready_1,
    output logic [DATA_W-1:0] resp_data_1,
    output logic              resp_zero_1,
    output logic              resp_neg_1,
    output logic              resp_par_1,
    output logic              busy
);
    state_e            state_q, state_d;
    logic              prio_q, prio_d, owner_q, owner_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]        op_q, op_d;
    logic              zero_q, zero_d, neg_q, neg_d, par_q, par_d;
    logic [1:0]        grant;
    logic [DATA_W-1:0] alu_y;

    alu_rr_pick u_pick (
        .valid_i({req_valid_1, req_valid_0}),
        .prio_i (prio_q),
        .grant_o(grant)
    );

    assign alu_y        = alu_calc(a_q, b_q, op_q);
    assign req_ready_0  = state_q == IDLE && grant[0];
    assign req_ready_1  = state_q == IDLE && grant[1];
    assign resp_valid_0 = state_q == RESP && !owner_q;
    assign resp_valid_1 = state_q == RESP && owner_q;
    assign resp_data_0  = res_q;
    assign resp_data_1  = res_q;
    assign resp_zero_0  = zero_q;
    assign resp_zero_1  = zero_q;
    assign resp_neg_0   = neg_q;
    assign resp_neg_1   = neg_q;
    assign resp_par_0   = par_q;
    assign resp_par_1   = par_q;
    assign busy         = state_q != IDLE;

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        owner_d = owner_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        par_d   = par_q;
        if (state_q == IDLE && |grant) begin
            state_d = EXEC;
            owner_d = grant[1];
            prio_d  = ~grant[1];
            a_d     = grant[1] ? req_a_1 : req_a_0;
            b_d     = grant[1] ? req_b_1 : req_b_0;
            op_d    = grant[1] ? req_op_1 : req_op_0;
        end else if (state_q == EXEC) begin
            state_d = RESP;
            res_d   = alu_y;
            zero_d  = alu_y == '0;
            neg_d   = alu_y[DATA_W-1];
            par_d   = ~^alu_y;
        end else if (state_q == RESP && (owner_q ? resp_ready_1 : resp_ready_0)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            prio_q  <= 1'b0;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            par_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            par_q   <= par_d;
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed and random traffic on both ports, checked by a queue scoreboard.
module tb_alu_share_ctrl;
    typedef struct packed {logic [19:0] d; logic z; logic n; logic p;} exp_t;

    logic        clk = 0, rst = 1, busy;
    logic        req_valid[2], req_ready[2], resp_valid[2], resp_ready[2];
    logic        resp_zero[2], resp_neg[2], resp_par[2], prev_rv[2];
    logic [19:0] req_a[2], req_b[2], resp_data[2];
    logic [2:0]  req_op[2];
    logic [22:0] held[2];
    int          errors = 0, checks = 0, cyc = 0, last_acc = 0;
    int          acc_cyc[2], n_acc[2];
    bit          m_prio = 0, tput = 0, tput_seen = 0, rnd_on = 0;
    exp_t        q0[$], q1[$];

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_0(req_valid[0]), .req_ready_0(req_ready[0]), .req_a_0(req_a[0]), .req_b_0(req_b[0]),
        .req_op_0(req_op[0]), .resp_valid_0(resp_valid[0]), .resp_ready_0(resp_ready[0]),
        .resp_data_0(resp_data[0]), .resp_zero_0(resp_zero[0]), .resp_neg_0(resp_neg[0]), .resp_par_0(resp_par[0]),
        .req_valid_1(req_valid[1]), .req_ready_1(req_ready[1]), .req_a_1(req_a[1]), .req_b_1(req_b[1]),
        .req_op_1(req_op[1]), .resp_valid_1(resp_valid[1]), .resp_ready_1(resp_ready[1]),
        .resp_data_1(resp_data[1]), .resp_zero_1(resp_zero[1]), .resp_neg_1(resp_neg[1]), .resp_par_1(resp_par[1]),
        .busy(busy)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endfunction

    // Reference: opcode semantics in 32-bit unsigned arithmetic, reduced modulo 2^20.
    function automatic exp_t model(logic [19:0] a, logic [19:0] b, logic [2:0] op);
        int unsigned x = a, y = b, r;
        exp_t e;
        case (op)
            3'd0: r = x + y;
            3'd1: r = x - y;
            3'd2: r = x | y;
            3'd3: r = ~(x & y);
            3'd4: r = x << (y % 32);
            default: r = 0;
        endcase
        r = r % (1 << 20);
        e.d = 20'(r);
        e.z = r == 0;
        e.n = r >= (1 << 19);
        e.p = ($countones(r) % 2) == 0;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_prio = 0;
            prev_rv[0] = 0;
            prev_rv[1] = 0;
        end else begin
            chk("ready_while_busy", busy && (req_ready[0] || req_ready[1]), 0);
            chk("ready_onehot", req_ready[0] && req_ready[1], 0);
            for (int p = 0; p < 2; p++) if (req_valid[p] && req_ready[p]) begin
                if (req_valid[1-p]) chk("rr_grant", p, m_prio);
                m_prio = (p == 0);
                if (tput && tput_seen) chk("tput_gap", cyc - last_acc, 3);
                tput_seen = tput;
                last_acc = cyc;
                acc_cyc[p] = cyc;
                n_acc[p]++;
                e = model(req_a[p], req_b[p], req_op[p]);
                if (p == 0) q0.push_back(e); else q1.push_back(e);
            end
            if (!tput) tput_seen = 0;
            for (int p = 0; p < 2; p++) begin
                if (resp_valid[p]) begin
                    chk("other_valid_low", resp_valid[1-p], 0);
                    if (!prev_rv[p]) chk("latency", cyc - acc_cyc[p], 2);
                    else chk("hold_stable", {resp_data[p], resp_zero[p], resp_neg[p], resp_par[p]}, held[p]);
                    held[p] = {resp_data[p], resp_zero[p], resp_neg[p], resp_par[p]};
                    if (resp_ready[p]) begin
                        if ((p == 0 ? q0.size() : q1.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_resp port %0d: got a response, expected none", p);
                        end else begin
                            if (p == 0) e = q0.pop_front(); else e = q1.pop_front();
                            chk("data", resp_data[p], e.d);
                            chk("zero", resp_zero[p], e.z);
                            chk("neg", resp_neg[p], e.n);
                            chk("par", resp_par[p], e.p);
                        end
                    end
                end
                prev_rv[p] = resp_valid[p];
            end
        end
    end

    task automatic issue(input int p, input logic [19:0] a, input logic [19:0] b, input logic [2:0] op);
        @(posedge clk); #1;
        req_a[p] = a;
        req_b[p] = b;
        req_op[p] = op;
        req_valid[p] = 1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (req_ready[p]) begin
                @(posedge clk); #1;
                req_valid[p] = 0;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL accept_timeout port %0d: no req_ready in 400 cycles, expected one", p);
        req_valid[p] = 0;
    endtask

    task automatic issue_rand(input int p);
        logic [19:0] a = ($urandom_range(0, 3) == 0) ? 20'hFFFFF : 20'($urandom);
        issue(p, a, 20'($urandom), 3'($urandom_range(0, 7)));
    endtask

    task automatic expect_resp(input int p, input logic [19:0] d, input logic z, input logic n, input logic par);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (resp_valid[p]) begin
                chk("dir_data", resp_data[p], d);
                chk("dir_zero", resp_zero[p], z);
                chk("dir_neg", resp_neg[p], n);
                chk("dir_par", resp_par[p], par);
                chk("dir_other_valid", resp_valid[1-p], 0);
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL resp_timeout port %0d: no resp_valid in 20 cycles, expected one", p);
    endtask

    task automatic drain();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (q0.size() == 0 && q1.size() == 0 && !busy) break;
        end
        chk("drain", q0.size() + q1.size() + int'(busy), 0);
    endtask

    initial begin
        int a0, a1;
        for (int p = 0; p < 2; p++) begin
            req_valid[p] = 0; req_a[p] = 0; req_b[p] = 0; req_op[p] = 0;
            resp_ready[p] = 0; prev_rv[p] = 0; held[p] = 0; acc_cyc[p] = 0; n_acc[p] = 0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", {resp_valid[1], resp_valid[0]}, 0);
        chk("rst_req_ready", {req_ready[1], req_ready[0]}, 0);
        chk("rst_data", resp_data[0], 0);
        chk("rst_flags", {resp_zero[0], resp_neg[0], resp_par[0]}, 0);
        resp_ready[0] = 1;
        resp_ready[1] = 1;

        issue(0, 20'h00005, 20'h00003, 3'b000);
        expect_resp(0, 20'h00008, 0, 0, 0);
        issue(1, 20'h00000, 20'h00001, 3'b001);
        expect_resp(1, 20'hFFFFF, 0, 1, 1);

        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        a0 = n_acc[0];
        a1 = n_acc[1];
        fork
            begin issue(0, 20'h00001, 20'h00013, 3'b100); expect_resp(0, 20'h80000, 0, 1, 0); end
            begin issue(1, 20'h12345, 20'h00ABC, 3'b111); expect_resp(1, 20'h00000, 1, 0, 1); end
        join
        chk("p0_first", acc_cyc[0] < acc_cyc[1], 1);
        chk("ready_pulses", (n_acc[0] - a0) * 16 + (n_acc[1] - a1), 17);

        resp_ready[0] = 0;
        issue_rand(0);
        fork issue_rand(1); join_none
        repeat (6) begin
            @(negedge clk);
            chk("hold_busy", busy, 1);
            chk("hold_ready1", req_ready[1], 0);
        end
        @(posedge clk); #1 resp_ready[0] = 1;
        wait fork;
        drain();

        issue_rand(0);
        rst = 1;
        @(posedge clk); #1 rst = 0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_exec_no_resp", {resp_valid[1], resp_valid[0]}, 0);
            chk("rst_exec_busy", busy, 0);
        end
        fork issue_rand(0); issue_rand(1); join
        chk("post_rst_p0_first", acc_cyc[0] < acc_cyc[1], 1);
        drain();

        tput = 1;
        fork
            begin for (int k = 0; k < 6; k++) issue_rand(0); end
            begin for (int k = 0; k < 6; k++) issue_rand(1); end
        join
        tput = 0;
        drain();

        rnd_on = 1;
        fork
            while (rnd_on) begin
                @(posedge clk); #1;
                resp_ready[0] = 1'($urandom);
                resp_ready[1] = 1'($urandom);
            end
        join_none
        fork
            begin for (int k = 0; k < 30; k++) begin repeat ($urandom_range(0, 3)) @(posedge clk); issue_rand(0); end end
            begin for (int k = 0; k < 30; k++) begin repeat ($urandom_range(0, 3)) @(posedge clk); issue_rand(1); end end
        join
        rnd_on = 0;
        repeat (2) @(posedge clk);
        #2;
        resp_ready[0] = 1;
        resp_ready[1] = 1;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: still running at 500000ns, expected finish");
        $fatal(1);
    end
endmodule
